// File: rtl/ahbl_reg_bank_if.sv
// AHB-Lite slave port bundle for the register bank (address/data phase signals).
// Latency: none, wires only.
// Backpressure: HREADYOUT is the slave's stall; HREADY is the bus-level ready seen by all slaves.
interface ahbl_reg_bank_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahbl_reg_bank.sv
// AHB-Lite register bank: NREGS 32-bit registers, byte-lane writes, read-only slots fed from ro_in.
// Latency: legal transfers complete with zero wait states; illegal ones take the two-cycle ERROR response.
// Backpressure: HREADYOUT drops only in the first ERROR cycle; no other stalls are generated.
module ahbl_reg_bank #(
    parameter int          NREGS   = 4,
    parameter logic [31:0] RST_VAL = 32'h0,
    parameter logic [15:0] RO_MASK = 16'h0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahbl_reg_bank_if.slave        bus,
    output logic [NREGS*32-1:0]   regs_o,
    output logic [NREGS-1:0]      wr_pulse_o,
    input  logic [NREGS*32-1:0]   ro_in
);

    typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;

    localparam logic [4:0] NREGS_W = 5'(NREGS);

    state_t      state;
    logic        hreadyout_q;
    logic        hresp_q;

    logic        dp_vld;
    logic        dp_write;
    logic [3:0]  dp_idx;
    logic [3:0]  dp_strb;
    logic        dp_wr;

    logic [3:0]  idx;
    logic [3:0]  strb;
    logic        illegal;
    logic        accept;

    // Upper address bits, transfer-type LSB and ro_in slices of writable slots carry no meaning here.
    logic        unused_bits;
    assign unused_bits = ^{ro_in, bus.HADDR[31:6], bus.HTRANS[0]};

    assign idx    = bus.HADDR[5:2];
    // The first ERROR cycle never accepts a new address phase; the bus is stalled there.
    assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY & (state != ERR1);

    // Decode byte strobes from size/offset and flag every illegal transfer condition.
    always_comb begin
        strb    = 4'b0000;
        illegal = 1'b0;
        case (bus.HSIZE)
            3'd0: strb = 4'b0001 << bus.HADDR[1:0];
            3'd1: begin
                strb    = bus.HADDR[1] ? 4'b1100 : 4'b0011;
                illegal = bus.HADDR[0];
            end
            3'd2: begin
                strb    = 4'b1111;
                illegal = |bus.HADDR[1:0];
            end
            default: illegal = 1'b1;
        endcase
        if ({1'b0, idx} >= NREGS_W) begin
            illegal = 1'b1;
        end
        if (bus.HWRITE && RO_MASK[idx]) begin
            illegal = 1'b1;
        end
    end

    // Error-response FSM with registered HREADYOUT/HRESP.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else if (state == ERR1) begin
            state       <= ERR2;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b1;
        end else if (accept && illegal) begin
            state       <= ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
        end else begin
            state       <= IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end
    end

    // Capture the address phase of a legal transfer for use in its data phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_vld   <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= 4'd0;
            dp_strb  <= 4'd0;
        end else begin
            dp_vld   <= accept & ~illegal;
            dp_write <= bus.HWRITE;
            dp_idx   <= idx;
            dp_strb  <= strb;
        end
    end

    // Reset in the data phase must suppress both the pulse and the register update.
    assign dp_wr         = dp_vld & dp_write & ~HRESET;
    assign bus.HREADYOUT = hreadyout_q | HRESET;
    assign bus.HRESP     = hresp_q & ~HRESET;

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        assign wr_pulse_o[g] = dp_wr && (dp_idx == 4'(g));

        if (RO_MASK[g]) begin : g_ro
            assign regs_o[g*32 +: 32] = ro_in[g*32 +: 32];
        end else begin : g_rw
            logic [31:0] r;

            // Byte-lane write from the data-phase HWDATA on the edge closing the data phase.
            always_ff @(posedge HCLK) begin
                if (HRESET) begin
                    r <= RST_VAL;
                end else if (wr_pulse_o[g]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (dp_strb[b]) begin
                            r[8*b +: 8] <= bus.HWDATA[8*b +: 8];
                        end
                    end
                end
            end

            assign regs_o[g*32 +: 32] = r;
        end
    end

    // Full-word read of the indexed slot during a read data phase, zero otherwise.
    always_comb begin
        bus.HRDATA = 32'h0;
        if (dp_vld && !dp_write) begin
            for (int i = 0; i < NREGS; i++) begin
                if (dp_idx == 4'(i)) begin
                    bus.HRDATA = regs_o[i*32 +: 32];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahbl_reg_bank.sv
// Directed bench for ahbl_reg_bank with a queue-based scoreboard.
// Driver pushes one expected entry per data-phase cycle; monitor pops on every observed data-phase cycle.
// Bus HREADY is looped back from HREADYOUT (single-slave system).
module tb_ahbl_reg_bank;

    localparam logic [31:0] RV = 32'hA0A0_0000;

    typedef struct {
        string       name;
        logic        rdy;
        logic        resp;
        logic [31:0] rdata;
        logic [3:0]  wp;
    } exp_t;

    logic         HCLK = 1'b0;
    logic         HRESET = 1'b1;
    logic [127:0] regs_o;
    logic [3:0]   wr_pulse_o;
    logic [127:0] ro_in;

    ahbl_reg_bank_if bus();

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   in_dp  = 1'b0;

    assign bus.HREADY = bus.HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahbl_reg_bank #(
        .NREGS   (4),
        .RST_VAL (RV),
        .RO_MASK (16'h0008)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .bus        (bus.slave),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o),
        .ro_in      (ro_in)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input logic rdy, input logic resp,
                        input logic [31:0] rd, input logic [3:0] wp);
        exp_t e;
        e.name  = nm;
        e.rdy   = rdy;
        e.resp  = resp;
        e.rdata = rd;
        e.wp    = wp;
        q.push_back(e);
    endtask

    task automatic push_err(input string nm);
        push({nm, "_e1"}, 1'b0, 1'b1, 32'h0, 4'b0000);
        push({nm, "_e2"}, 1'b1, 1'b1, 32'h0, 4'b0000);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HADDR  = 32'h0;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'd2;
    endtask

    task automatic adr(input logic [31:0] a, input logic w, input logic [2:0] sz);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = a;
        bus.HWRITE = w;
        bus.HSIZE  = sz;
    endtask

    task automatic chk_regs(input string nm, input logic [31:0] r0, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] r3);
        @(negedge HCLK);
        chk({nm, "_r0"}, regs_o[31:0],   r0);
        chk({nm, "_r1"}, regs_o[63:32],  r1);
        chk({nm, "_r2"}, regs_o[95:64],  r2);
        chk({nm, "_r3"}, regs_o[127:96], r3);
    endtask

    // Monitor: compare each data-phase cycle against the queue; outside data phases expect a quiet bus.
    always @(negedge HCLK) begin
        exp_t e;
        if (in_dp) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_dphase: got data phase expected none");
            end else begin
                e = q.pop_front();
                chk({e.name, "_rdy"},  32'(bus.HREADYOUT), 32'(e.rdy));
                chk({e.name, "_resp"}, 32'(bus.HRESP),     32'(e.resp));
                chk({e.name, "_rdat"}, bus.HRDATA,         e.rdata);
                chk({e.name, "_wp"},   32'(wr_pulse_o),    32'(e.wp));
            end
        end else begin
            chk("quiet_rdy",  32'(bus.HREADYOUT), 32'd1);
            chk("quiet_resp", 32'(bus.HRESP),     32'd0);
            chk("quiet_rdat", bus.HRDATA,         32'd0);
            chk("quiet_wp",   32'(wr_pulse_o),    32'd0);
        end
        in_dp = !HRESET && ((bus.HSEL && bus.HTRANS[1] && bus.HREADY) || (in_dp && !bus.HREADYOUT));
    end

    initial begin
        idle();
        bus.HWDATA = 32'h0;
        ro_in      = {32'h0000_CAFE, 96'h0};
        tick();
        tick();
        chk_regs("reset", RV, RV, RV, 32'h0000_CAFE);
        HRESET = 1'b0;
        tick();

        // Word write then back-to-back read of the same register.
        adr(32'h4, 1'b1, 3'd2);
        push("wr_dead", 1'b1, 1'b0, 32'h0, 4'b0010);
        tick();
        bus.HWDATA = 32'hDEAD_BEEF;
        adr(32'h4, 1'b0, 3'd2);
        push("rd_dead", 1'b1, 1'b0, 32'hDEAD_BEEF, 4'b0000);
        tick();
        idle();
        tick();
        chk_regs("after_word", RV, 32'hDEAD_BEEF, RV, 32'h0000_CAFE);
        tick();

        // Word, byte and halfword writes to register 0; junk in unselected lanes.
        adr(32'h0, 1'b1, 3'd2);
        push("wr_w0", 1'b1, 1'b0, 32'h0, 4'b0001);
        tick();
        bus.HWDATA = 32'h0;
        adr(32'h2, 1'b1, 3'd0);
        push("wr_b2", 1'b1, 1'b0, 32'h0, 4'b0001);
        tick();
        bus.HWDATA = 32'h11A5_2233;
        adr(32'h0, 1'b1, 3'd1);
        push("wr_h0", 1'b1, 1'b0, 32'h0, 4'b0001);
        tick();
        bus.HWDATA = 32'hFFFF_1234;
        adr(32'h0, 1'b0, 3'd0);
        push("rd_r0", 1'b1, 1'b0, 32'h00A5_1234, 4'b0000);
        tick();
        idle();
        tick();
        chk_regs("after_lanes", 32'h00A5_1234, 32'hDEAD_BEEF, RV, 32'h0000_CAFE);
        tick();

        // BUSY with HSEL, and NONSEQ without HSEL: no effect.
        adr(32'h0, 1'b1, 3'd2);
        bus.HTRANS = 2'b01;
        tick();
        bus.HWDATA = 32'h5555_5555;
        adr(32'h4, 1'b1, 3'd2);
        bus.HSEL = 1'b0;
        tick();
        bus.HWDATA = 32'h6666_6666;
        idle();
        tick();
        chk_regs("after_noop", 32'h00A5_1234, 32'hDEAD_BEEF, RV, 32'h0000_CAFE);
        tick();

        // Out-of-range write and HSIZE=3 read: two-cycle ERROR each, no writes.
        adr(32'h10, 1'b1, 3'd2);
        push_err("oor_wr");
        tick();
        bus.HWDATA = 32'hFFFF_FFFF;
        idle();
        tick();
        tick();
        adr(32'h0, 1'b0, 3'd3);
        push_err("size3");
        tick();
        idle();
        tick();
        tick();
        chk_regs("after_oor", 32'h00A5_1234, 32'hDEAD_BEEF, RV, 32'h0000_CAFE);
        tick();

        // Unaligned word read, then a misaligned halfword in ERR2, then a legal read in ERR2.
        adr(32'h2, 1'b0, 3'd2);
        push_err("unal_w");
        tick();
        idle();
        tick();
        adr(32'h1, 1'b0, 3'd1);
        push_err("unal_h");
        tick();
        idle();
        tick();
        adr(32'h0, 1'b0, 3'd2);
        push("rd_after_err", 1'b1, 1'b0, 32'h00A5_1234, 4'b0000);
        tick();
        idle();
        tick();
        tick();

        // Read-only slot 3: read returns ro_in, write is an ERROR.
        adr(32'hC, 1'b0, 3'd2);
        push("rd_ro", 1'b1, 1'b0, 32'h0000_CAFE, 4'b0000);
        tick();
        adr(32'hC, 1'b1, 3'd2);
        push_err("wr_ro");
        tick();
        bus.HWDATA = 32'hFFFF_FFFF;
        idle();
        tick();
        tick();
        chk_regs("after_ro", 32'h00A5_1234, 32'hDEAD_BEEF, RV, 32'h0000_CAFE);
        tick();

        // Reset asserted in the data phase of a write to register 2.
        adr(32'h8, 1'b1, 3'd2);
        push("rst_wr", 1'b1, 1'b0, 32'h0, 4'b0000);
        tick();
        bus.HWDATA = 32'h0000_0001;
        HRESET = 1'b1;
        idle();
        tick();
        HRESET = 1'b0;
        chk_regs("after_rst", RV, RV, RV, 32'h0000_CAFE);
        tick();
        adr(32'h8, 1'b0, 3'd2);
        push("rd_after_rst", 1'b1, 1'b0, RV, 4'b0000);
        tick();
        idle();
        tick();
        tick();
        tick();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ahbl_reg_bank.md
AHBL_REG_BANK -- requirements
Module: ahbl_reg_bank

Interface

Parameters, one per line (name, default, meaning):
- REQ-001: The block SHALL have parameter NREGS, default 4: number of 32-bit registers, legal range 1..16.
- REQ-002: The block SHALL have parameter RST_VAL, default 32'h0: reset value of every read/write register.
- REQ-003: The block SHALL have parameter RO_MASK, default 16'h0: bit i=1 makes register i read-only; its value comes from ro_in.

Ports, one per line (name, direction, width, meaning):
- REQ-004: The block SHALL have port HCLK, input, 1: the single clock; all state is updated on its rising edge.
- REQ-005: The block SHALL have port HRESET, input, 1: reset, synchronous and active-high.
- REQ-006: The block SHALL have port HSEL, input, 1: slave select.
- REQ-007: The block SHALL have port HADDR, input, 32: address; HADDR[5:2] is the register index and HADDR[31:6] is ignored.
- REQ-008: The block SHALL have port HTRANS, input, 2: transfer type; a transfer is active when HTRANS[1]=1 (NONSEQ or SEQ).
- REQ-009: The block SHALL have ports HWRITE (input, 1: write), HSIZE (input, 3: transfer size) and HREADY (input, 1: bus ready).
- REQ-010: The block SHALL have port HWDATA, input, 32: write data, valid in the data phase.
- REQ-011: The block SHALL have ports HREADYOUT (output, 1), HRESP (output, 1: 0=OKAY, 1=ERROR) and HRDATA (output, 32).
- REQ-012: The block SHALL have port regs_o, output, NREGS*32: register i is on bits [32i+31:32i].
- REQ-013: The block SHALL have port wr_pulse_o, output, NREGS: bit i pulses for one cycle when register i is written.
- REQ-014: The block SHALL have port ro_in, input, NREGS*32: values returned for read-only registers.

Function

- REQ-015: An address phase SHALL be accepted when HSEL=1, HTRANS[1]=1 and HREADY=1; index, write, size and byte offset are then registered for the data phase.
- REQ-016: A transfer SHALL be illegal if any of these holds:
  - index >= NREGS;
  - HSIZE > 2;
  - HSIZE=1 with HADDR[0]=1;
  - HSIZE=2 with HADDR[1:0]!=0;
  - HWRITE=1 to a register with its RO_MASK bit set.
- REQ-017: A legal transfer SHALL complete with zero wait states: data phase HREADYOUT=1, HRESP=0.
- REQ-018: An illegal transfer SHALL give the two-cycle AHB-Lite error response: cycle 1 HREADYOUT=0, HRESP=1; cycle 2 HREADYOUT=1, HRESP=1; then return to idle.
- REQ-019: The control state machine SHALL have exactly three states: IDLE, ERR1, ERR2.
  - IDLE→ERR1 on an accepted illegal transfer;
  - ERR1→ERR2 unconditionally;
  - ERR2→IDLE, or ERR2→ERR1 if another illegal transfer is accepted in that cycle.
- REQ-020: A legal write SHALL update only the byte lanes selected by size and offset:
  - byte: lane HADDR[1:0];
  - halfword: lanes {HADDR[1],0} and {HADDR[1],1};
  - word: all four lanes.
- REQ-021: Write data SHALL be taken from HWDATA in the data phase, and the register SHALL update on the clock edge ending the data phase.
- REQ-022: wr_pulse_o[i] SHALL be high for exactly the cycle in which register i updates, and never for illegal transfers.
- REQ-023: During a read data phase, HRDATA SHALL equal the full 32-bit value of the indexed register (ro_in slice for read-only registers), independent of size; it SHALL be 0 otherwise.
- REQ-024: A read issued in the cycle after a write to the same register SHALL return the newly written value.
- REQ-025: IDLE/BUSY transfers, HSEL=0, or HREADY=0 SHALL cause no state change and an OKAY, zero-wait response.
- REQ-026: An illegal transfer SHALL cause no register write.
- REQ-027: regs_o SHALL reflect register contents; read-only slots SHALL reflect ro_in.

Reset

- REQ-028: While HRESET=1 at a rising HCLK edge:
  - all read/write registers SHALL be set to RST_VAL;
  - the state machine SHALL go to IDLE;
  - any pending data phase SHALL be discarded;
  - wr_pulse_o SHALL be 0, HREADYOUT=1, HRESP=0.
- REQ-029: Reset asserted in the middle of a data phase or error response SHALL abort it with no write, and the block SHALL be idle on the next cycle.

Verification

- REQ-030: The bench SHALL cover word write then read: write 32'hDEADBEEF to 0x4, then read 0x4 → HRDATA=32'hDEADBEEF; wr_pulse_o[1] high one cycle; both transfers OKAY with zero waits.
- REQ-031: The bench SHALL cover byte and halfword writes: word 32'h0 to 0x0, byte 8'hA5 to 0x2, halfword 16'h1234 to 0x0 → register 0 = 32'h00A51234.
- REQ-032: The bench SHALL cover an out-of-range write: NREGS=4, write to 0x10 → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); no register changes; wr_pulse_o stays 0.
- REQ-033: The bench SHALL cover an unaligned access: word read at 0x2 → two-cycle ERROR; next legal read of 0x0 → OKAY with the correct data.
- REQ-034: The bench SHALL cover a read-only register: RO_MASK=4'b1000, ro_in slot 3 = 32'h0000CAFE; read 0xC → 32'h0000CAFE; write 0xC → ERROR, with ro_in unaffected.
- REQ-035: The bench SHALL cover reset mid-transfer: HRESET asserted during the data phase of a write of 32'h1 to 0x8 → register 2 = RST_VAL; wr_pulse_o never asserted.
